// File: rtl/dpi_seq_pkg.sv
// Shared types and constants for the DPI stream sequencer and its config table.
package dpi_seq_pkg;

  localparam int SID_W   = 6;
  localparam int NUM_SID = 64;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_STREAM,
    S_DRAIN,
    S_COMMIT
  } seq_state_e;

endpackage

// File: rtl/dpi_seq_cfg_table.sv
// Per-stream enable-mask table and seen bitmap; async read, writes visible next cycle.
// Clearing the whole seen bitmap overrides a same-cycle seen-set.
module dpi_seq_cfg_table
  import dpi_seq_pkg::*;
#(
  parameter int NUM_REGEX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [SID_W-1:0]     wr_sid,
  input  logic [NUM_REGEX-1:0] wr_mask,
  input  logic [SID_W-1:0]     rd_sid,
  output logic [NUM_REGEX-1:0] rd_mask,
  output logic                 rd_seen,
  input  logic                 seen_set,
  input  logic [SID_W-1:0]     seen_sid,
  input  logic                 seen_clr
);

  logic [NUM_REGEX-1:0] mask_q [NUM_SID];
  logic [NUM_REGEX-1:0] mask_d [NUM_SID];
  logic [NUM_SID-1:0]   seen_q;
  logic [NUM_SID-1:0]   seen_d;

  always_comb begin
    mask_d = mask_q;
    seen_d = seen_q;
    if (wr_en)    mask_d[wr_sid] = wr_mask;
    if (seen_set) seen_d[seen_sid] = 1'b1;
    if (seen_clr) seen_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SID; i++) mask_q[i] <= '0;
      seen_q <= '0;
    end else begin
      mask_q <= mask_d;
      seen_q <= seen_d;
    end
  end

  assign rd_mask = mask_q[rd_sid];
  assign rd_seen = seen_q[rd_sid];

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Finger front-end: restore, stream (1-cycle char latency), drain, commit; pkt_rdy low outside STREAM except stray-beat discard.
// Optional DPI_SEQ_STATS_EN adds saturating packet and drop counters.
module dpi_stream_sequencer
  import dpi_seq_pkg::*;
#(
  parameter int NUM_REGEX = 8,
  parameter int LOAD_GAP  = 2,
  parameter int DRAIN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           pkt_data,
  input  logic                 pkt_vld,
  input  logic                 pkt_sop,
  input  logic                 pkt_eop,
  input  logic [SID_W-1:0]     pkt_sid,
  output logic                 pkt_rdy,
  input  logic                 cfg_we,
  input  logic [SID_W-1:0]     cfg_sid,
  input  logic [NUM_REGEX-1:0] cfg_mask,
  input  logic                 cfg_clr_seen,
  output logic [SID_W-1:0]     stream_id,
  output logic                 new_stream_id,
  output logic                 load_state,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic [NUM_REGEX-1:0] enable,
`ifdef DPI_SEQ_STATS_EN
  output logic [31:0]          stat_pkts,
  output logic [15:0]          stat_drops,
`endif
  output logic                 busy
);

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SID_W-1:0]     sid_q, sid_d;
  logic [NUM_REGEX-1:0] mask_q, mask_d;
  logic                 seen_lat_q, seen_lat_d;
  logic                 load_state_q, load_state_d;
  logic                 new_sid_q, new_sid_d;
  logic [7:0]           char_in_q, char_in_d;
  logic                 char_vld_q, char_vld_d;
  logic                 eop_q, eop_d;
  logic [NUM_REGEX-1:0] enable_q, enable_d;
  logic                 busy_q, busy_d;

  logic [NUM_REGEX-1:0] tbl_mask;
  logic                 tbl_seen;
  logic                 seen_set;
  logic                 drop_beat;

  assign seen_set  = (state_q == S_COMMIT) && (|mask_q);
  assign drop_beat = (state_q == S_IDLE) && pkt_vld && !pkt_sop;

  dpi_seq_cfg_table #(.NUM_REGEX(NUM_REGEX)) u_cfg_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_we),
    .wr_sid   (cfg_sid),
    .wr_mask  (cfg_mask),
    .rd_sid   (pkt_sid),
    .rd_mask  (tbl_mask),
    .rd_seen  (tbl_seen),
    .seen_set (seen_set),
    .seen_sid (sid_q),
    .seen_clr (cfg_clr_seen)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sid_d      = sid_q;
    mask_d     = mask_q;
    seen_lat_d = seen_lat_q;
    case (state_q)
      S_IDLE: if (pkt_vld && pkt_sop) begin
        state_d    = S_LOAD;
        sid_d      = pkt_sid;
        mask_d     = tbl_mask;
        seen_lat_d = tbl_seen;
      end
      S_LOAD: begin
        state_d = S_GAP;
        cnt_d   = CNT_W'(LOAD_GAP - 1);
      end
      S_GAP: if (cnt_q == '0) state_d = S_STREAM;
             else             cnt_d   = cnt_q - 1'b1;
      // Framing belongs upstream: only eop ends the packet, a sop here is plain data.
      S_STREAM: if (pkt_vld && pkt_eop) begin
        state_d = S_DRAIN;
        cnt_d   = CNT_W'(DRAIN_CYC - 1);
      end
      S_DRAIN: if (cnt_q == '0) state_d = S_COMMIT;
               else             cnt_d   = cnt_q - 1'b1;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    load_state_d = (state_d == S_LOAD);
    new_sid_d    = (state_d == S_LOAD) && !seen_lat_d;
    char_vld_d   = (state_q == S_STREAM) && pkt_vld;
    char_in_d    = char_vld_d ? pkt_data : char_in_q;
    eop_d        = (state_d == S_COMMIT);
    enable_d     = eop_d ? mask_d : '0;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sid_q        <= '0;
      mask_q       <= '0;
      seen_lat_q   <= 1'b0;
      load_state_q <= 1'b0;
      new_sid_q    <= 1'b0;
      char_in_q    <= '0;
      char_vld_q   <= 1'b0;
      eop_q        <= 1'b0;
      enable_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sid_q        <= sid_d;
      mask_q       <= mask_d;
      seen_lat_q   <= seen_lat_d;
      load_state_q <= load_state_d;
      new_sid_q    <= new_sid_d;
      char_in_q    <= char_in_d;
      char_vld_q   <= char_vld_d;
      eop_q        <= eop_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
    end
  end

  assign pkt_rdy       = !rst && (drop_beat || (state_q == S_STREAM));
  assign stream_id     = sid_q;
  assign new_stream_id = new_sid_q;
  assign load_state    = load_state_q;
  assign char_in       = char_in_q;
  assign char_in_vld   = char_vld_q;
  assign eop           = eop_q;
  assign enable        = enable_q;
  assign busy          = busy_q;

`ifdef DPI_SEQ_STATS_EN
  logic [31:0] stat_pkts_q, stat_pkts_d;
  logic [15:0] stat_drops_q, stat_drops_d;

  always_comb begin
    stat_pkts_d  = stat_pkts_q;
    stat_drops_d = stat_drops_q;
    if (state_q == S_COMMIT && stat_pkts_q != '1) stat_pkts_d  = stat_pkts_q + 1'b1;
    if (drop_beat && stat_drops_q != '1)          stat_drops_d = stat_drops_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q  <= '0;
      stat_drops_q <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_drops_q <= stat_drops_d;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_drops = stat_drops_q;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Scoreboard bench for dpi_stream_sequencer: expected loads, chars and commits queued at drive time.
module tb_dpi_stream_sequencer;

  localparam int NR = 8;
  localparam int LG = 2;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    pkt_data = '0;
  logic          pkt_vld = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
  logic [5:0]    pkt_sid = '0;
  logic          pkt_rdy;
  logic          cfg_we = 1'b0, cfg_clr_seen = 1'b0;
  logic [5:0]    cfg_sid = '0;
  logic [NR-1:0] cfg_mask = '0;
  logic [5:0]    stream_id;
  logic          new_stream_id, load_state, char_in_vld, eop, busy;
  logic [7:0]    char_in;
  logic [NR-1:0] enable;
`ifdef DPI_SEQ_STATS_EN
  logic [31:0]   stat_pkts;
  logic [15:0]   stat_drops;
`endif

  dpi_stream_sequencer #(.NUM_REGEX(NR), .LOAD_GAP(LG), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .pkt_sid(pkt_sid), .pkt_rdy(pkt_rdy), .cfg_we(cfg_we),
    .cfg_sid(cfg_sid), .cfg_mask(cfg_mask), .cfg_clr_seen(cfg_clr_seen),
    .stream_id(stream_id), .new_stream_id(new_stream_id), .load_state(load_state),
    .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop), .enable(enable),
`ifdef DPI_SEQ_STATS_EN
    .stat_pkts(stat_pkts), .stat_drops(stat_drops),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_pkts = 0;

  logic          exp_load_q[$];
  logic [7:0]    exp_char_q[$];
  logic [NR-1:0] exp_eop_q[$];
  logic [7:0]    pkt_bytes[8];

  int load_cyc, first_char_cyc, last_char_cyc, eop_cyc, nchar;

  always @(posedge clk) cyc++;

  // Output monitor: every finger-side event must match the head of its queue.
  always @(negedge clk) begin
    if (load_state) begin
      n_checks++;
      if (exp_load_q.size() == 0) begin
        n_fail++; $display("FAIL unexpected_load new_stream_id=%0b", new_stream_id);
      end else begin
        logic e;
        e = exp_load_q.pop_front();
        if (new_stream_id !== e) begin
          n_fail++; $display("FAIL new_stream_id got=%0b exp=%0b", new_stream_id, e);
        end
      end
      load_cyc = cyc; nchar = 0;
    end
    if (char_in_vld) begin
      n_checks++;
      if (exp_char_q.size() == 0) begin
        n_fail++; $display("FAIL unexpected_char got=%h", char_in);
      end else begin
        logic [7:0] e;
        e = exp_char_q.pop_front();
        if (char_in !== e) begin
          n_fail++; $display("FAIL char_in got=%h exp=%h", char_in, e);
        end
      end
      if (nchar == 0) first_char_cyc = cyc;
      last_char_cyc = cyc; nchar++;
    end
    if (eop) begin
      n_checks++;
      if (exp_eop_q.size() == 0) begin
        n_fail++; $display("FAIL unexpected_eop enable=%h", enable);
      end else begin
        logic [NR-1:0] e;
        e = exp_eop_q.pop_front();
        if (enable !== e) begin
          n_fail++; $display("FAIL eop_enable got=%h exp=%h", enable, e);
        end
      end
      eop_cyc = cyc;
    end else if (enable !== '0) begin
      n_checks++; n_fail++; $display("FAIL enable_without_eop got=%h", enable);
    end
  end

  task automatic cfg_write(input logic [5:0] sid, input logic [NR-1:0] m);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_sid = sid; cfg_mask = m;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic clr_seen();
    @(posedge clk); #1;
    cfg_clr_seen = 1'b1;
    @(posedge clk); #1;
    cfg_clr_seen = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = !busy && exp_eop_q.size() == 0;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL %s_timeout busy=%0b pending_eop=%0d", name, busy, exp_eop_q.size());
    end
  endtask

  task automatic send_pkt(input logic [5:0] sid, input int n, input logic exp_new,
                          input logic [NR-1:0] exp_en);
    bit acc;
    exp_load_q.push_back(exp_new);
    exp_eop_q.push_back(exp_en);
    for (int i = 0; i < n; i++) exp_char_q.push_back(pkt_bytes[i]);
    exp_pkts++;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      pkt_vld = 1'b1; pkt_sop = (i == 0); pkt_eop = (i == n - 1);
      pkt_data = pkt_bytes[i];
      pkt_sid = (i == 0) ? sid : 6'h3f;
      acc = 0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk); acc = pkt_rdy;
        @(posedge clk); #1;
      end
      n_checks++;
      if (!acc) begin
        n_fail++; $display("FAIL accept_timeout byte=%0d got_rdy=0 exp_rdy=1", i);
        break;
      end
    end
    pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    wait_done("send_pkt");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({pkt_rdy, load_state, char_in_vld, eop, busy, new_stream_id} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {pkt_rdy, load_state, char_in_vld, eop, busy, new_stream_id});
    end
    n_checks++;
    if (enable !== '0 || stream_id !== '0 || char_in !== '0) begin
      n_fail++; $display("FAIL reset_data enable=%h sid=%h char=%h exp=0", enable, stream_id, char_in);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pkts = 0;
  endtask

  task automatic test_basic();
    pkt_bytes[0] = 8'h61; pkt_bytes[1] = 8'h62; pkt_bytes[2] = 8'h63; pkt_bytes[3] = 8'h64;
    cfg_write(6'd5, 8'h03);
    send_pkt(6'd5, 4, 1'b1, 8'h03);
    n_checks++;
    if (nchar != 4) begin n_fail++; $display("FAIL basic_nchar got=%0d exp=4", nchar); end
    n_checks++;
    if (first_char_cyc - load_cyc != 1 + LG + 1) begin
      n_fail++; $display("FAIL basic_first_char_lat got=%0d exp=%0d", first_char_cyc - load_cyc, 1 + LG + 1);
    end
    n_checks++;
    if (last_char_cyc - first_char_cyc != 3) begin
      n_fail++; $display("FAIL basic_char_span got=%0d exp=3", last_char_cyc - first_char_cyc);
    end
    n_checks++;
    if (eop_cyc - last_char_cyc != DC) begin
      n_fail++; $display("FAIL basic_drain_lat got=%0d exp=%0d", eop_cyc - last_char_cyc, DC);
    end
    n_checks++;
    if (stream_id !== 6'd5) begin n_fail++; $display("FAIL basic_stream_id got=%0d exp=5", stream_id); end
  endtask

  task automatic test_seen();
    send_pkt(6'd5, 4, 1'b0, 8'h03);
    clr_seen();
    send_pkt(6'd5, 4, 1'b1, 8'h03);
  endtask

  task automatic test_mask_zero();
    pkt_bytes[0] = 8'h5a; pkt_bytes[1] = 8'ha5;
    send_pkt(6'd9, 2, 1'b1, 8'h00);
    send_pkt(6'd9, 2, 1'b1, 8'h00);
  endtask

  task automatic test_drops();
    logic [7:0] beats[2];
    beats[0] = 8'h11; beats[1] = 8'h22;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = beats[i];
      @(negedge clk);
      n_checks++;
      if (pkt_rdy !== 1'b1) begin n_fail++; $display("FAIL drop_rdy got=%0b exp=1", pkt_rdy); end
    end
    @(posedge clk); #1;
    pkt_vld = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got=%0b exp=0", busy); end
`ifdef DPI_SEQ_STATS_EN
    n_checks++;
    if (stat_drops !== 16'd2) begin n_fail++; $display("FAIL stat_drops got=%0d exp=2", stat_drops); end
    n_checks++;
    if (stat_pkts !== 32'(exp_pkts)) begin
      n_fail++; $display("FAIL stat_pkts got=%0d exp=%0d", stat_pkts, exp_pkts);
    end
`endif
  endtask

  task automatic test_cfg_midpkt();
    pkt_bytes[0] = 8'h61; pkt_bytes[1] = 8'h62; pkt_bytes[2] = 8'h63; pkt_bytes[3] = 8'h64;
    fork
      send_pkt(6'd5, 4, 1'b0, 8'h03);
      begin
        bit seen_vld = 0;
        for (int t = 0; t < 50 && !seen_vld; t++) begin @(negedge clk); seen_vld = char_in_vld; end
        n_checks++;
        if (!seen_vld) begin n_fail++; $display("FAIL midpkt_stream_timeout got=0 exp=1"); end
        cfg_write(6'd5, 8'h80);
      end
    join
    send_pkt(6'd5, 4, 1'b0, 8'h80);
  endtask

  task automatic test_rst_mid();
    bit in_stream = 0;
    cfg_write(6'd12, 8'h0f);
    exp_load_q.push_back(1'b1);
    @(posedge clk); #1;
    pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_data = 8'h78; pkt_sid = 6'd12;
    for (int t = 0; t < 20 && !in_stream; t++) begin @(negedge clk); in_stream = pkt_rdy; end
    n_checks++;
    if (!in_stream) begin n_fail++; $display("FAIL rstmid_stream_timeout got=0 exp=1"); end
    exp_char_q.push_back(8'h78);
    @(posedge clk); #1;
    rst = 1'b1; pkt_vld = 1'b0; pkt_sop = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({pkt_rdy, load_state, char_in_vld, eop, busy, new_stream_id} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_ctrl got=%b exp=000000",
               {pkt_rdy, load_state, char_in_vld, eop, busy, new_stream_id});
    end
    n_checks++;
    if (enable !== '0 || stream_id !== '0 || char_in !== '0) begin
      n_fail++; $display("FAIL rstmid_data enable=%h sid=%h char=%h exp=0", enable, stream_id, char_in);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pkts = 0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || exp_char_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_idle busy=%0b pending_chars=%0d exp=0", busy, exp_char_q.size());
    end
    pkt_bytes[0] = 8'h7e;
    send_pkt(6'd12, 1, 1'b1, 8'h00);
`ifdef DPI_SEQ_STATS_EN
    n_checks++;
    if (stat_pkts !== 32'(exp_pkts) || stat_drops !== 16'd0) begin
      n_fail++; $display("FAIL stats_after_rst pkts=%0d drops=%0d exp=%0d/0", stat_pkts, stat_drops, exp_pkts);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seen();
    test_mask_zero();
    test_drops();
    test_cfg_midpkt();
    test_rst_mid();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_load_q.size() != 0 || exp_char_q.size() != 0 || exp_eop_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain loads=%0d chars=%0d eops=%0d exp=0",
               exp_load_q.size(), exp_char_q.size(), exp_eop_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
